vc_test_mem_initiator_1port: RTL and testbench

Self-checking memory request initiator that acts as the client end of a single memory port. It writes a known data pattern to a block of words, reads the block back, and checks every response against the expected type, opaque tag and data. Random inter-request gaps come from an internal LFSR. The block drives a test memory, such as the random-delay test memory, in unit tests of the memory message path.

---
 rtl/vc_test_mem_initiator_1port.sv | 208 ++++++++++++++++++++
 tb/tb_vc_test_mem_initiator_1port.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_test_mem_initiator_1port.sv
// Self-checking memory initiator: writes a pattern to a block of words, reads it
// back and counts response mismatches. Inter-request gaps come from a 16-bit LFSR.
module vc_test_mem_initiator_1port #(
  parameter int unsigned p_opaque_nbits    = 8,
  parameter int unsigned p_addr_nbits      = 32,
  parameter int unsigned p_data_nbits      = 32,
  parameter int unsigned p_num_words       = 16,
  parameter logic [p_addr_nbits-1:0] p_base_addr = '0,
  parameter int unsigned p_max_outstanding = 4,
  parameter logic [15:0] p_lfsr_seed       = 16'hACE1
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [31:0]                                      max_delay,
  output logic                                             memreq_val,
  input  logic                                             memreq_rdy,
  output logic [3+p_opaque_nbits+p_addr_nbits+2+p_data_nbits-1:0] memreq_msg,
  input  logic                                             memresp_val,
  output logic                                             memresp_rdy,
  input  logic [3+p_opaque_nbits+2+p_data_nbits-1:0]       memresp_msg,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             pass,
  output logic [15:0]                                      num_errors
);

  localparam int unsigned REQ_W  = 3 + p_opaque_nbits + p_addr_nbits + 2 + p_data_nbits;
  localparam int unsigned RESP_W = 3 + p_opaque_nbits + 2 + p_data_nbits;
  localparam int unsigned IW     = 17;
  localparam int unsigned OW     = $clog2(p_max_outstanding + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(p_num_words - 1);
  localparam logic [OW-1:0] MAX_OUT  = OW'(p_max_outstanding);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_DRAIN, S_RD, S_RD_DRAIN, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [IW-1:0]            chk_q, chk_d;
  logic [OW-1:0]            outst_q, outst_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [7:0]               gap_q, gap_d;
  logic [15:0]              errors_q, errors_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic                     busy_q, busy_d;
  logic                     req_val_q, req_val_d;
  logic                     resp_rdy_q, resp_rdy_d;
  logic [REQ_W-1:0]         req_msg_q, req_msg_d;

  logic                      req_fire, resp_fire, resp_ok, resp_err, wr_phase;
  logic [2:0]                resp_type;
  logic [p_opaque_nbits-1:0] resp_opaque;
  logic [1:0]                resp_len;
  logic [p_data_nbits-1:0]   resp_data;
  logic [p_addr_nbits-1:0]   req_addr;
  logic                      unused_bits;

  function automatic logic [p_data_nbits-1:0] pattern(input logic [15:0] i);
    return p_data_nbits'(32'hC0DE_0000 | {16'h0000, i});
  endfunction

  assign resp_type   = memresp_msg[RESP_W-1 -: 3];
  assign resp_opaque = memresp_msg[RESP_W-4 -: p_opaque_nbits];
  assign resp_len    = memresp_msg[p_data_nbits+1 -: 2];
  assign resp_data   = memresp_msg[p_data_nbits-1:0];
  assign unused_bits = ^{max_delay[31:8], resp_len};

  assign req_fire  = req_val_q & memreq_rdy;
  assign resp_fire = memresp_val & resp_rdy_q;
  assign resp_ok   = resp_fire && (outst_q != '0);
  assign wr_phase  = (state_q == S_WR) || (state_q == S_WR_DRAIN);

  always_comb begin
    resp_err = 1'b0;
    if (resp_fire) begin
      if (outst_q == '0)
        resp_err = 1'b1;
      else if (resp_opaque != p_opaque_nbits'(chk_q))
        resp_err = 1'b1;
      else if (resp_type != (wr_phase ? 3'd1 : 3'd0))
        resp_err = 1'b1;
      else if (!wr_phase && (resp_data != pattern(chk_q[15:0])))
        resp_err = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    outst_d  = outst_q;
    lfsr_d   = lfsr_q;
    gap_d    = gap_q;
    errors_d = errors_q;
    done_d   = done_q;
    pass_d   = pass_q;

    if (req_fire) begin
      idx_d  = idx_q + IW'(1);
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      gap_d  = lfsr_q[7:0] & max_delay[7:0];
    end else if (gap_q != 8'd0) begin
      gap_d = gap_q - 8'd1;
    end

    case ({req_fire, resp_ok})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    // A stray response (nothing outstanding) is an error but never advances the check index.
    if (resp_ok)
      chk_d = chk_q + IW'(1);
    if (resp_err && (errors_q != 16'hFFFF))
      errors_d = errors_q + 16'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_WR;
          errors_d = 16'd0;
          pass_d   = 1'b0;
          done_d   = 1'b0;
          idx_d    = '0;
          chk_d    = '0;
          outst_d  = '0;
        end
      end
      S_WR: if (req_fire && (idx_q == LAST_IDX)) state_d = S_WR_DRAIN;
      S_WR_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_RD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      S_RD: if (req_fire && (idx_q == LAST_IDX)) state_d = S_RD_DRAIN;
      S_RD_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (errors_d == 16'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so nothing depends on memreq_rdy combinationally.
  always_comb begin
    req_val_d  = ((state_d == S_WR) || (state_d == S_RD)) &&
                 (gap_d == 8'd0) && (outst_d < MAX_OUT);
    busy_d     = (state_d == S_WR) || (state_d == S_WR_DRAIN) ||
                 (state_d == S_RD) || (state_d == S_RD_DRAIN);
    resp_rdy_d = busy_d;
    req_addr   = p_base_addr + (p_addr_nbits'(idx_d) << 2);
    req_msg_d  = {(state_d == S_WR) ? 3'd1 : 3'd0,
                  p_opaque_nbits'(idx_d),
                  req_addr,
                  2'b00,
                  (state_d == S_WR) ? pattern(idx_d[15:0]) : {p_data_nbits{1'b0}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      chk_q      <= '0;
      outst_q    <= '0;
      lfsr_q     <= p_lfsr_seed;
      gap_q      <= 8'd0;
      errors_q   <= 16'd0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      req_val_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      req_msg_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      outst_q    <= outst_d;
      lfsr_q     <= lfsr_d;
      gap_q      <= gap_d;
      errors_q   <= errors_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      req_val_q  <= req_val_d;
      resp_rdy_q <= resp_rdy_d;
      req_msg_q  <= req_msg_d;
    end
  end

  assign memreq_val  = req_val_q;
  assign memreq_msg  = req_msg_q;
  assign memresp_rdy = resp_rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign num_errors  = errors_q;

endmodule

// File: tb/tb_vc_test_mem_initiator_1port.sv
// Bench for vc_test_mem_initiator_1port: a one-cycle-latency memory model plus
// a request scoreboard filled with the expected write/read sequence per run.
module tb_vc_test_mem_initiator_1port;
  localparam int O = 8, A = 32, D = 32, N = 16;
  localparam int REQ_W = 3 + O + A + 2 + D;
  localparam int RESP_W = 3 + O + 2 + D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [31:0] max_delay = 32'd0;
  logic memreq_val;
  logic memreq_rdy = 1'b0;
  logic [REQ_W-1:0] memreq_msg;
  logic memresp_val = 1'b0;
  logic memresp_rdy;
  logic [RESP_W-1:0] memresp_msg = '0;
  logic busy, done, pass;
  logic [15:0] num_errors;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  bit rdy_ctrl = 1'b1;
  bit hold = 1'b0;
  int corrupt_word = -1;

  logic [REQ_W-1:0] exp_q[$];
  logic [RESP_W-1:0] resp_q[$];
  int acc_stamp[$];
  bit acc_wr[$];
  int acc_gap[$];
  logic [31:0] mem [0:N-1];
  logic [15:0] lfsr_m = 16'hACE1;
  bit pend_req = 1'b0;
  bit pend_resp = 1'b0;
  logic [REQ_W-1:0] pend_msg = '0;

  vc_test_mem_initiator_1port dut (
    .clk(clk), .reset(reset), .start(start), .max_delay(max_delay),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .busy(busy), .done(done), .pass(pass), .num_errors(num_errors)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk_req(input bit wr, input int i);
    logic [31:0] data;
    logic [31:0] addr;
    data = wr ? (32'hC0DE_0000 | 32'(i)) : 32'd0;
    addr = 32'(4 * i);
    return {wr ? 3'd1 : 3'd0, 8'(i), addr, 2'b00, data};
  endfunction

  // Memory side of one accepted request: scoreboard check, LFSR model, response.
  task automatic mem_accept(input logic [REQ_W-1:0] msg);
    logic [REQ_W-1:0] e;
    logic [2:0] typ;
    logic [7:0] opq;
    logic [31:0] rd;
    int widx;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL req_scoreboard: unexpected request got=%h required=none", msg);
    end else begin
      e = exp_q.pop_front();
      if (msg !== e) begin
        n_err++;
        $display("FAIL req_msg: got=%h required=%h", msg, e);
      end
    end
    typ = msg[REQ_W-1 -: 3];
    opq = msg[REQ_W-4 -: 8];
    widx = int'(msg[D+2+5 : D+2+2]);
    acc_stamp.push_back(cycle);
    acc_wr.push_back(typ == 3'd1);
    acc_gap.push_back(int'(lfsr_m[7:0] & max_delay[7:0]));
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    if (typ == 3'd1) begin
      mem[widx] = msg[D-1:0];
      rd = 32'd0;
    end else begin
      rd = mem[widx];
      if (widx == corrupt_word) rd = 32'hC0DE_0007;
    end
    resp_q.push_back({typ, opq, 2'b00, rd});
  endtask

  // Handshakes seen at a posedge are processed at the following negedge.
  always @(negedge clk) begin
    cycle++;
    if (!reset) begin
      resp_q.delete();
      exp_q.delete();
      lfsr_m = 16'hACE1;
      memreq_rdy = rdy_ctrl;
      memresp_val = 1'b0;
      pend_req = 1'b0;
      pend_resp = 1'b0;
    end else begin
      if (pend_resp && resp_q.size() != 0) void'(resp_q.pop_front());
      if (pend_req) mem_accept(pend_msg);
      memreq_rdy = rdy_ctrl;
      memresp_val = !hold && (resp_q.size() != 0);
      memresp_msg = (resp_q.size() != 0) ? resp_q[0] : '0;
      pend_req = memreq_val && memreq_rdy;
      pend_msg = memreq_msg;
      pend_resp = memresp_val && memresp_rdy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic new_run();
    acc_stamp.delete();
    acc_wr.delete();
    acc_gap.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(mk_req(1'b1, i));
    for (int i = 0; i < N; i++) exp_q.push_back(mk_req(1'b0, i));
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 20000) begin
      tick();
      c++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_timeout: done=%b required=1", tag, done);
    end
  endtask

  task automatic check_run_end(input string tag, input logic [15:0] exp_errs, input logic exp_pass);
    n_cmp++;
    if (num_errors !== exp_errs) begin
      n_err++;
      $display("FAIL %s_num_errors: got=%0d required=%0d", tag, num_errors, exp_errs);
    end
    n_cmp++;
    if (pass !== exp_pass) begin
      n_err++;
      $display("FAIL %s_pass: got=%b required=%b", tag, pass, exp_pass);
    end
    n_cmp++;
    if (acc_stamp.size() !== 2 * N) begin
      n_err++;
      $display("FAIL %s_accept_count: got=%0d required=%0d", tag, acc_stamp.size(), 2 * N);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s_leftover_expected: got=%0d required=0", tag, exp_q.size());
    end
    $display("run %s: errors=%0d pass=%b accepts=%0d", tag, num_errors, pass, acc_stamp.size());
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({memreq_val, memresp_rdy, busy, done, pass} !== 5'b0 || num_errors !== 16'd0) begin
      n_err++;
      $display("FAIL reset_values: got val=%b rdy=%b busy=%b done=%b pass=%b err=%0d required all 0",
               memreq_val, memresp_rdy, busy, done, pass, num_errors);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    max_delay = 32'd0;
    new_run();
    do_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy: got=%b required=1", busy);
    end
    wait_done("basic");
    check_run_end("basic", 16'd0, 1'b1);
    for (int k = 0; k + 1 < acc_stamp.size(); k++) begin
      if (acc_wr[k] == acc_wr[k+1]) begin
        n_cmp++;
        if (acc_stamp[k+1] - acc_stamp[k] !== 1) begin
          n_err++;
          $display("FAIL basic_back_to_back: pair %0d spacing=%0d required=1", k,
                   acc_stamp[k+1] - acc_stamp[k]);
        end
      end
    end
    repeat (3) tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_held: done=%b busy=%b required done=1 busy=0", done, busy);
    end
  endtask

  task automatic test_bad_read();
    corrupt_word = 3;
    new_run();
    do_start();
    wait_done("bad_read");
    check_run_end("bad_read", 16'd1, 1'b0);
    corrupt_word = -1;
  endtask

  task automatic test_withhold();
    hold = 1'b1;
    new_run();
    do_start();
    repeat (30) tick();
    n_cmp++;
    if (acc_stamp.size() !== 4) begin
      n_err++;
      $display("FAIL withhold_accepts: got=%0d required=4", acc_stamp.size());
    end
    n_cmp++;
    if (memreq_val !== 1'b0) begin
      n_err++;
      $display("FAIL withhold_val: got=%b required=0", memreq_val);
    end
    hold = 1'b0;
    wait_done("withhold");
    check_run_end("withhold", 16'd0, 1'b1);
  endtask

  task automatic test_rdy_stall();
    logic [REQ_W-1:0] snap;
    int c;
    new_run();
    do_start();
    c = 0;
    while (acc_stamp.size() < 3 && c < 200) begin
      tick();
      c++;
    end
    rdy_ctrl = 1'b0;
    snap = memreq_msg;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (memreq_val !== 1'b1 || memreq_msg !== snap) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: val=%b msg=%h required val=1 msg=%h", k, memreq_val,
                 memreq_msg, snap);
      end
    end
    rdy_ctrl = 1'b1;
    wait_done("stall");
    check_run_end("stall", 16'd0, 1'b1);
  endtask

  task automatic test_gap();
    apply_reset();
    max_delay = 32'h0000_00FF;
    new_run();
    do_start();
    wait_done("gap");
    check_run_end("gap", 16'd0, 1'b1);
    for (int k = 0; k + 1 < acc_stamp.size(); k++) begin
      if (acc_wr[k] == acc_wr[k+1]) begin
        n_cmp++;
        if (acc_stamp[k+1] - acc_stamp[k] !== acc_gap[k] + 1) begin
          n_err++;
          $display("FAIL gap_spacing: pair %0d spacing=%0d required=%0d", k,
                   acc_stamp[k+1] - acc_stamp[k], acc_gap[k] + 1);
        end
      end
    end
    max_delay = 32'd0;
  endtask

  task automatic test_reset_mid_rd();
    int c;
    int nrd;
    new_run();
    do_start();
    c = 0;
    nrd = 0;
    while (nrd < 2 && c < 500) begin
      tick();
      c++;
      nrd = 0;
      foreach (acc_wr[k]) if (!acc_wr[k]) nrd++;
    end
    n_cmp++;
    if (nrd < 2) begin
      n_err++;
      $display("FAIL midreset_reach_rd: reads=%0d required>=2", nrd);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({memreq_val, memresp_rdy, busy, done, pass} !== 5'b0 || num_errors !== 16'd0) begin
      n_err++;
      $display("FAIL midreset_values: val=%b rdy=%b busy=%b done=%b pass=%b err=%0d required all 0",
               memreq_val, memresp_rdy, busy, done, pass, num_errors);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    new_run();
    do_start();
    wait_done("after_reset");
    check_run_end("after_reset", 16'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_read();
    test_withhold();
    test_rdy_stall();
    test_gap();
    test_reset_mid_rd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
